// File: rtl/link_stack.sv
// -----------------------------------------------------------------------------
// link_stack
//   Parametrised call/return and data stack that replaces the single LNK
//   register. CALL pushes the return address pc_in+1 and PUSH pushes data_in.
//   RET and POP both pop into the registered pop_data output, which is flagged
//   by a one-cycle pop_vld pulse. Overflow and underflow are reported through
//   sticky flags instead of corrupting the stack.
//
// Parameters
//   DW     data / PC width in bits
//   DEPTH  number of entries (>= 2, power of two)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active-low
//   call      push return address pc_in+1 (highest priority)
//   ret       pop to pop_data
//   push      push data_in
//   pop       pop to pop_data (lowest priority)
//   pc_in     current PC
//   data_in   PUSH operand
//   clr_err   clear sticky ovf/unf
//   pop_data  registered popped value
//   pop_vld   one-cycle pulse, pop_data was updated by RET/POP
//   LNK       current top of stack, 0 when empty
//   count     entries in use, 0..DEPTH
//   full      count == DEPTH
//   empty     count == 0
//   ovf       sticky: CALL/PUSH issued while full
//   unf       sticky: RET/POP issued while empty
//
// Configuration macro
//   LINK_STACK_CIRCULAR_EN  when defined, CALL/PUSH on a full stack overwrites
//                           the oldest entry (ring buffer) while still setting
//                           ovf; when undefined the write is refused.
// -----------------------------------------------------------------------------
module link_stack #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              pc_in,
    input  logic [DW-1:0]              data_in,
    input  logic                       clr_err,
    output logic [DW-1:0]              pop_data,
    output logic                       pop_vld,
    output logic [DW-1:0]              LNK,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       unf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    // wr_ptr is the slot the next push lands in; the top of stack sits one
    // below it. Keeping it separate from count lets the ring-buffer build
    // keep advancing past the oldest entry while count saturates at DEPTH.
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] top_ptr;

    logic          do_push;
    logic          do_pop;
    logic          push_ok;
    logic          pop_ok;
    logic          new_ovf;
    logic          new_unf;
    logic [DW-1:0] push_val;

    assign top_ptr = wr_ptr - AW'(1);

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign LNK   = empty ? '0 : mem[top_ptr];

    // Only one operation per cycle: call > ret > push > pop. A lower request
    // in the same cycle as a higher one is simply dropped.
    assign do_push  = call | (~ret & push);
    assign do_pop   = ~call & (ret | (~push & pop));
    assign push_val = call ? (pc_in + DW'(1)) : data_in;

`ifdef LINK_STACK_CIRCULAR_EN
    assign push_ok = do_push;
`else
    assign push_ok = do_push & ~full;
`endif
    assign pop_ok  = do_pop & ~empty;
    assign new_ovf = do_push & full;
    assign new_unf = do_pop & empty;

    // Storage has no reset: contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_val;
        end
    end

    // Pointer, occupancy, pop output and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            count    <= '0;
            pop_data <= '0;
            pop_vld  <= 1'b0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
        end else begin
            pop_vld <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (!full) begin
                    count <= count + (AW + 1)'(1);
                end
            end else if (pop_ok) begin
                wr_ptr   <= top_ptr;
                count    <= count - (AW + 1)'(1);
                pop_data <= mem[top_ptr];
            end
            // A fresh error in the clearing cycle keeps the flag set.
            ovf <= (ovf & ~clr_err) | new_ovf;
            unf <= (unf & ~clr_err) | new_unf;
        end
    end

endmodule

// File: tb/tb_link_stack.sv
module tb_link_stack;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst;
    logic          call;
    logic          ret;
    logic          push;
    logic          pop;
    logic [DW-1:0] pc_in;
    logic [DW-1:0] data_in;
    logic          clr_err;
    logic [DW-1:0] pop_data;
    logic          pop_vld;
    logic [DW-1:0] LNK;
    logic [3:0]    count;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;

    int checks;
    int failures;

    // Behavioural model: a queue whose back is the top of stack.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_pd;
    logic          exp_vld;
    logic          exp_ovf;
    logic          exp_unf;

    link_stack #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .call     (call),
        .ret      (ret),
        .push     (push),
        .pop      (pop),
        .pc_in    (pc_in),
        .data_in  (data_in),
        .clr_err  (clr_err),
        .pop_data (pop_data),
        .pop_vld  (pop_vld),
        .LNK      (LNK),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .ovf      (ovf),
        .unf      (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        exp_pd  = '0;
        exp_vld = 1'b0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
    endtask

    task automatic model_push(input logic [DW-1:0] v, output logic refused);
        refused = 1'b0;
        if (mq.size() < DEPTH) begin
            mq.push_back(v);
        end else begin
            refused = 1'b1;
`ifdef LINK_STACK_CIRCULAR_EN
            void'(mq.pop_front());
            mq.push_back(v);
`endif
        end
    endtask

    task automatic model_pop(output logic refused);
        refused = 1'b0;
        if (mq.size() > 0) begin
            exp_pd  = mq.pop_back();
            exp_vld = 1'b1;
        end else begin
            refused = 1'b1;
        end
    endtask

    task automatic model_apply(input logic c, input logic r, input logic p, input logic o,
                               input logic [DW-1:0] pc, input logic [DW-1:0] d, input logic clr);
        logic nov;
        logic nun;
        nov = 1'b0;
        nun = 1'b0;
        exp_vld = 1'b0;
        if (c)      model_push(pc + 8'd1, nov);
        else if (r) model_pop(nun);
        else if (p) model_push(d, nov);
        else if (o) model_pop(nun);
        exp_ovf = (exp_ovf && !clr) || nov;
        exp_unf = (exp_unf && !clr) || nun;
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model on the
    // rising edge and leave the caller sampling 1 time unit later.
    task automatic drive_cycle(input logic c, input logic r, input logic p, input logic o,
                               input logic [DW-1:0] pc, input logic [DW-1:0] d, input logic clr);
        @(negedge clk);
        call = c; ret = r; push = p; pop = o;
        pc_in = pc; data_in = d; clr_err = clr;
        @(posedge clk);
        model_apply(c, r, p, o, pc, d, clr);
        #1;
    endtask

    task automatic idle_cycle();
        drive_cycle(0, 0, 0, 0, 8'h00, 8'h00, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        call = 0; ret = 0; push = 0; pop = 0; clr_err = 0;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        apply_reset();
        drive_cycle(0, 0, 1, 0, 8'h00, 8'hA5, 0);
        drive_cycle(0, 0, 1, 0, 8'h00, 8'h5A, 0);
        drive_cycle(0, 0, 0, 1, 8'h00, 8'h00, 0);
        // Asynchronous reset mid-cycle, away from any edge.
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (count !== 4'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++;
        if (empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
        checks++;
        if (LNK !== 8'h00) begin failures++; $display("[TB] FAIL reset_lnk: got %h expected 00", LNK); end
        checks++;
        if (ovf !== 1'b0 || unf !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got ovf=%b unf=%b expected 0 0", ovf, unf); end
        checks++;
        if (pop_vld !== 1'b0 || pop_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_pop: got vld=%b data=%h expected 0 00", pop_vld, pop_data); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_call_ret();
        $display("[TB] test_call_ret");
        apply_reset();
        drive_cycle(1, 0, 0, 0, 8'h10, 8'h00, 0);
        checks++;
        if (LNK !== 8'h11 || count !== 4'd1) begin failures++; $display("[TB] FAIL call_lnk: got lnk=%h count=%0d expected 11 1", LNK, count); end
        checks++;
        if (pop_vld !== 1'b0) begin failures++; $display("[TB] FAIL call_novld: got %b expected 0", pop_vld); end
        drive_cycle(0, 1, 0, 0, 8'h00, 8'h00, 0);
        checks++;
        if (pop_data !== 8'h11 || pop_vld !== 1'b1) begin failures++; $display("[TB] FAIL ret_data: got data=%h vld=%b expected 11 1", pop_data, pop_vld); end
        checks++;
        if (empty !== 1'b1 || LNK !== 8'h00) begin failures++; $display("[TB] FAIL ret_empty: got empty=%b lnk=%h expected 1 00", empty, LNK); end
        idle_cycle();
        checks++;
        if (pop_vld !== 1'b0) begin failures++; $display("[TB] FAIL ret_pulse: got %b expected 0", pop_vld); end
    endtask

    task automatic test_push_pop();
        logic [DW-1:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h2B; vals[2] = 8'h42;
        $display("[TB] test_push_pop");
        apply_reset();
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 1, 0, 8'h00, vals[i], 0);
        checks++;
        if (count !== 4'd3 || LNK !== 8'h42) begin failures++; $display("[TB] FAIL push3: got count=%0d lnk=%h expected 3 42", count, LNK); end
        for (int i = 2; i >= 0; i--) begin
            drive_cycle(0, 0, 0, 1, 8'h00, 8'h00, 0);
            checks++;
            if (pop_data !== vals[i] || pop_vld !== 1'b1 || count !== 4'(i)) begin
                failures++;
                $display("[TB] FAIL pop_order: got data=%h vld=%b count=%0d expected %h 1 %0d", pop_data, pop_vld, count, vals[i], i);
            end
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] want;
        $display("[TB] test_overflow");
        apply_reset();
        for (int i = 1; i <= 9; i++) drive_cycle(0, 0, 1, 0, 8'h00, 8'(i), 0);
        checks++;
        if (full !== 1'b1 || ovf !== 1'b1 || count !== 4'd8) begin failures++; $display("[TB] FAIL ovf_flags: got full=%b ovf=%b count=%0d expected 1 1 8", full, ovf, count); end
`ifdef LINK_STACK_CIRCULAR_EN
        want = 8'h09;
`else
        want = 8'h08;
`endif
        drive_cycle(0, 0, 0, 1, 8'h00, 8'h00, 0);
        checks++;
        if (pop_data !== want || pop_vld !== 1'b1) begin failures++; $display("[TB] FAIL ovf_pop: got data=%h vld=%b expected %h 1", pop_data, pop_vld, want); end
        checks++;
        if (ovf !== 1'b1 || full !== 1'b0) begin failures++; $display("[TB] FAIL ovf_sticky: got ovf=%b full=%b expected 1 0", ovf, full); end
    endtask

    task automatic test_underflow();
        $display("[TB] test_underflow");
        apply_reset();
        drive_cycle(0, 0, 1, 0, 8'h00, 8'h3C, 0);
        drive_cycle(0, 0, 0, 1, 8'h00, 8'h00, 0);
        drive_cycle(0, 0, 0, 1, 8'h00, 8'h00, 0);
        checks++;
        if (unf !== 1'b1 || pop_vld !== 1'b0 || pop_data !== 8'h3C) begin failures++; $display("[TB] FAIL unf_set: got unf=%b vld=%b data=%h expected 1 0 3C", unf, pop_vld, pop_data); end
        drive_cycle(0, 0, 0, 1, 8'h00, 8'h00, 1);
        checks++;
        if (unf !== 1'b1) begin failures++; $display("[TB] FAIL unf_clr_collide: got %b expected 1", unf); end
        drive_cycle(0, 0, 0, 0, 8'h00, 8'h00, 1);
        checks++;
        if (unf !== 1'b0 || count !== 4'd0) begin failures++; $display("[TB] FAIL unf_clr: got unf=%b count=%0d expected 0 0", unf, count); end
    endtask

    task automatic test_wrap();
        $display("[TB] test_wrap");
        apply_reset();
        drive_cycle(1, 0, 1, 0, 8'hFF, 8'h55, 0);
        checks++;
        if (count !== 4'd1 || LNK !== 8'h00) begin failures++; $display("[TB] FAIL wrap_call: got count=%0d lnk=%h expected 1 00", count, LNK); end
        drive_cycle(0, 1, 0, 1, 8'h00, 8'h00, 0);
        checks++;
        if (pop_data !== 8'h00 || pop_vld !== 1'b1 || count !== 4'd0) begin failures++; $display("[TB] FAIL wrap_ret: got data=%h vld=%b count=%0d expected 00 1 0", pop_data, pop_vld, count); end
    endtask

    task automatic test_random();
        logic          c, r, p, o, clr;
        logic [DW-1:0] pc, d, exp_lnk;
        $display("[TB] test_random");
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            c   = ($urandom_range(0, 5) == 0);
            r   = ($urandom_range(0, 5) == 0);
            p   = ($urandom_range(0, 2) == 0);
            o   = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 15) == 0);
            pc  = 8'($urandom);
            d   = 8'($urandom);
            drive_cycle(c, r, p, o, pc, d, clr);
            exp_lnk = (mq.size() > 0) ? mq[$] : 8'h00;
            checks++;
            if (count !== 4'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin
                failures++;
                $display("[TB] FAIL rnd_count: cycle %0d got count=%0d full=%b empty=%b expected %0d", n, count, full, empty, mq.size());
            end
            checks++;
            if (LNK !== exp_lnk) begin failures++; $display("[TB] FAIL rnd_lnk: cycle %0d got %h expected %h", n, LNK, exp_lnk); end
            checks++;
            if (pop_vld !== exp_vld || pop_data !== exp_pd) begin
                failures++;
                $display("[TB] FAIL rnd_pop: cycle %0d got vld=%b data=%h expected %b %h", n, pop_vld, pop_data, exp_vld, exp_pd);
            end
            checks++;
            if (ovf !== exp_ovf || unf !== exp_unf) begin
                failures++;
                $display("[TB] FAIL rnd_err: cycle %0d got ovf=%b unf=%b expected %b %b", n, ovf, unf, exp_ovf, exp_unf);
            end
        end
    endtask

    task automatic test_reset_abort();
        $display("[TB] test_reset_abort");
        apply_reset();
        drive_cycle(0, 0, 1, 0, 8'h00, 8'h77, 0);
        drive_cycle(0, 0, 0, 1, 8'h00, 8'h00, 0);
        checks++;
        if (pop_vld !== 1'b1) begin failures++; $display("[TB] FAIL abort_pre: got %b expected 1", pop_vld); end
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (pop_vld !== 1'b0 || pop_data !== 8'h00) begin failures++; $display("[TB] FAIL abort_vld: got vld=%b data=%h expected 0 00", pop_vld, pop_data); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b0;
        call = 0; ret = 0; push = 0; pop = 0; clr_err = 0;
        pc_in = '0; data_in = '0;
        model_reset();
        test_reset();
        test_call_ret();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_wrap();
        test_random();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
